// File: rtl/minv_host_ctrl_if.sv
// Word-serial link between the host sequencer (master) and the 256-bit
// modular-inverse unit (slave): load/unload strobes, data words, completion.
interface minv_host_ctrl_if #(
  parameter int W = 16
);
  logic [W-1:0] datain;
  logic         loada;
  logic         loadp;
  logic         minv_en;
  logic         outx1;
  logic         outx2;
  logic         outt;
  logic         minv_rdy;
  logic [1:0]   minv_flag;
  logic [W-1:0] regx1out;
  logic [W-1:0] regx2out;
  logic [W-1:0] regtout_16;

  modport master (
    output datain, loada, loadp, minv_en, outx1, outx2, outt,
    input  minv_rdy, minv_flag, regx1out, regx2out, regtout_16
  );

  modport slave (
    input  datain, loada, loadp, minv_en, outx1, outx2, outt,
    output minv_rdy, minv_flag, regx1out, regx2out, regtout_16
  );
endinterface

// File: rtl/minv_host_ctrl.sv
// Host sequencer for the modular-inverse unit: serializes a/p, starts the unit,
// unloads the flagged result register. Optional WAIT timeout: MINV_TIMEOUT_EN.
module minv_host_ctrl #(
  parameter int W     = 16,
  parameter int WORDS = 16,
  parameter int OPW   = W * WORDS
`ifdef MINV_TIMEOUT_EN
  , parameter int TIMEOUT = 8192
`endif
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  input  logic [OPW-1:0] a_i,
  input  logic [OPW-1:0] p_i,
  output logic           busy_o,
  output logic           done_o,
  output logic           err_o,
  output logic [OPW-1:0] result_o,
  minv_host_ctrl_if.master unit
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_P, S_START, S_WAIT, S_UNLOAD, S_DONE
  } state_t;

  localparam int            CW   = $clog2(WORDS);
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  localparam logic [1:0] FLAG_X1  = 2'b00;
  localparam logic [1:0] FLAG_X2  = 2'b01;
  localparam logic [1:0] FLAG_T   = 2'b11;
  localparam logic [1:0] FLAG_BAD = 2'b10;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [OPW-1:0] a_q, a_d;
  logic [OPW-1:0] p_q, p_d;
  logic [OPW-1:0] res_q, res_d;
  logic [1:0]     flag_q, flag_d;
  logic           err_q, err_d;
  logic           guard_q, guard_d;
  logic [W-1:0]   unload_word;

`ifdef MINV_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wcnt_q, wcnt_d;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; all state, including the wide shift
  // registers, is cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      p_q     <= '0;
      res_q   <= '0;
      flag_q  <= '0;
      err_q   <= 1'b0;
      guard_q <= 1'b0;
`ifdef MINV_TIMEOUT_EN
      wcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      p_q     <= p_d;
      res_q   <= res_d;
      flag_q  <= flag_d;
      err_q   <= err_d;
      guard_q <= guard_d;
`ifdef MINV_TIMEOUT_EN
      wcnt_q  <= wcnt_d;
`endif
    end
  end

  always_comb begin
    unload_word = '0;
    case (flag_q)
      FLAG_X1: unload_word = unit.regx1out;
      FLAG_X2: unload_word = unit.regx2out;
      FLAG_T:  unload_word = unit.regtout_16;
      default: unload_word = '0;
    endcase
  end

  // NOTE: every next-state signal gets its hold value first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    p_d     = p_q;
    res_d   = res_q;
    flag_d  = flag_q;
    err_d   = err_q;
    guard_d = guard_q;
`ifdef MINV_TIMEOUT_EN
    wcnt_d  = wcnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          p_d     = p_i;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        a_d   = a_q >> W;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_LOAD_P;
      end
      S_LOAD_P: begin
        p_d   = p_q >> W;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_START;
      end
      S_START: begin
        guard_d = 1'b1;
`ifdef MINV_TIMEOUT_EN
        wcnt_d  = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // The first WAIT cycle may still see rdy left over from the last run.
        guard_d = 1'b0;
        if (!guard_q && unit.minv_rdy) begin
          flag_d = unit.minv_flag;
          if (unit.minv_flag == FLAG_BAD) begin
            err_d   = 1'b1;
            res_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d   = '0;
            state_d = S_UNLOAD;
          end
        end
`ifdef MINV_TIMEOUT_EN
        else if (wcnt_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          res_d   = '0;
          state_d = S_DONE;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
`endif
      end
      S_UNLOAD: begin
        // Words arrive LSW first; after WORDS shifts the first one is at the bottom.
        res_d = {unload_word, res_q[OPW-1:W]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign unit.loada   = (state_q == S_LOAD_A);
  assign unit.loadp   = (state_q == S_LOAD_P);
  assign unit.minv_en = (state_q == S_START);
  assign unit.datain  = unit.loada ? a_q[W-1:0] :
                        unit.loadp ? p_q[W-1:0] : '0;
  assign unit.outx1   = (state_q == S_UNLOAD) && (flag_q == FLAG_X1);
  assign unit.outx2   = (state_q == S_UNLOAD) && (flag_q == FLAG_X2);
  assign unit.outt    = (state_q == S_UNLOAD) && (flag_q == FLAG_T);

  assign busy_o   = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o   = (state_q == S_DONE);
  assign err_o    = err_q;
  assign result_o = res_q;

endmodule

// File: tb/tb_minv_host_ctrl.sv
// Self-checking bench for minv_host_ctrl with a behavioural model of the
// modular-inverse unit; directed and randomized operations.
module tb_minv_host_ctrl;

  localparam int W   = 16;
  localparam int OPW = 256;
`ifdef MINV_TIMEOUT_EN
  localparam int TMO = 8192;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start_i = 1'b0;
  logic [OPW-1:0] a_i = '0;
  logic [OPW-1:0] p_i = '0;
  logic           busy_o, done_o, err_o;
  logic [OPW-1:0] result_o;

  int errors = 0;
  int checks = 0;

  minv_host_ctrl_if #(.W(W)) u_if ();

  minv_host_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .a_i(a_i), .p_i(p_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .result_o(result_o),
    .unit(u_if)
  );

  always #5 clk = ~clk;

  // ---------------- unit model ----------------
  logic [1:0]     u_flag = 2'b00;
  logic [OPW-1:0] u_val = '0;
  int             u_delay = 1;
  bit             u_stale = 1'b0;
  bit             u_compute = 1'b0;
  bit             u_mute = 1'b0;

  logic [OPW-1:0] ua, up, x1, x2, tt;
  int             ucnt;

  assign u_if.regx1out   = x1[W-1:0];
  assign u_if.regx2out   = x2[W-1:0];
  assign u_if.regtout_16 = tt[W-1:0];

  function automatic logic [OPW-1:0] small_inv(input logic [OPW-1:0] a, input logic [OPW-1:0] p);
    longint pa, pp;
    pa = longint'(a[31:0]);
    pp = longint'(p[31:0]);
    for (longint x = 1; x < pp && x < 4096; x++)
      if ((pa * x) % pp == 1) return OPW'(x);
    return '0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ua <= '0; up <= '0; x1 <= '0; x2 <= '0; tt <= '0;
      u_if.minv_rdy <= 1'b0; u_if.minv_flag <= 2'b00; ucnt <= 0;
    end else begin
      if (u_if.loada) ua <= {u_if.datain, ua[OPW-1:W]};
      if (u_if.loadp) up <= {u_if.datain, up[OPW-1:W]};
      if (u_if.outx1) x1 <= x1 >> W;
      if (u_if.outx2) x2 <= x2 >> W;
      if (u_if.outt)  tt <= tt >> W;
      if (u_if.minv_en) begin
        x1 <= {8{32'hDEAD_0001}};
        x2 <= {8{32'hBEEF_0002}};
        tt <= {8{32'hCAFE_0003}};
        case (u_flag)
          2'b00: x1 <= u_compute ? small_inv(ua, up) : u_val;
          2'b01: x2 <= u_compute ? small_inv(ua, up) : u_val;
          2'b11: tt <= u_compute ? small_inv(ua, up) : u_val;
          default: ;
        endcase
        if (u_mute) begin
          u_if.minv_rdy <= 1'b0; ucnt <= 0;
        end else if (u_stale) begin
          u_if.minv_flag <= 2'b10; ucnt <= 1;   // stale rdy still high, bogus flag
        end else begin
          u_if.minv_rdy <= 1'b0; ucnt <= u_delay;
        end
      end else if (ucnt != 0) begin
        ucnt <= ucnt - 1;
        if (ucnt == 1) begin
          u_if.minv_rdy  <= 1'b1;
          u_if.minv_flag <= u_flag;
        end
      end
    end
  end

  // ---------------- strobe monitor ----------------
  int n_la = 0, n_lp = 0, n_en = 0, n_x1 = 0, n_x2 = 0, n_t = 0, n_viol = 0;
  always @(posedge clk) begin
    if (u_if.loada)   n_la <= n_la + 1;
    if (u_if.loadp)   n_lp <= n_lp + 1;
    if (u_if.minv_en) n_en <= n_en + 1;
    if (u_if.outx1)   n_x1 <= n_x1 + 1;
    if (u_if.outx2)   n_x2 <= n_x2 + 1;
    if (u_if.outt)    n_t  <= n_t + 1;
    if ((u_if.loada && u_if.loadp) ||
        (int'(u_if.outx1) + int'(u_if.outx2) + int'(u_if.outt) > 1) ||
        (!u_if.loada && !u_if.loadp && u_if.datain != '0))
      n_viol <= n_viol + 1;
  end

  task automatic check(input string tag, input logic [OPW-1:0] obs, input logic [OPW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OPW-1:0] rand256();
    logic [OPW-1:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic run_op(input string name, input logic [OPW-1:0] a, input logic [OPW-1:0] p,
                        input logic [1:0] f, input logic [OPW-1:0] v, input int delay,
                        input bit stale, input bit compute, input bit mute);
    int b_la, b_lp, b_en, b_x1, b_x2, b_t, b_v, n, limit, exp_lat;
    bit got, bad;
    logic [OPW-1:0] exp_res;
    bad = mute || (f == 2'b10);
    exp_res = bad ? '0 : v;
`ifdef MINV_TIMEOUT_EN
    if (mute) exp_lat = 33 + TMO;
    else
`endif
    exp_lat = (f == 2'b10) ? 34 + (stale ? 1 : delay) : 50 + (stale ? 1 : delay);
    limit = mute ? 20000 : 2000;
    u_flag = f; u_val = v; u_delay = delay; u_stale = stale; u_compute = compute; u_mute = mute;
    b_la = n_la; b_lp = n_lp; b_en = n_en; b_x1 = n_x1; b_x2 = n_x2; b_t = n_t; b_v = n_viol;
    @(negedge clk);
    start_i = 1'b1; a_i = a; p_i = p;
    @(negedge clk);
    start_i = 1'b0; a_i = rand256(); p_i = rand256();
    check({name, ":busy_after_start"}, OPW'(busy_o), OPW'(1));
    n = 0; got = 1'b0;
    while (!got && n < limit) begin
      if (done_o) got = 1'b1;
      else begin
        @(negedge clk);
        n++;
        if (n == 20) start_i = 1'b1;      // ignored outside IDLE
        if (n == 21) start_i = 1'b0;
      end
    end
    check({name, ":done_seen"}, OPW'(got), OPW'(1));
    check({name, ":latency"}, OPW'(n), OPW'(exp_lat));
    check({name, ":err"}, OPW'(err_o), OPW'(bad));
    check({name, ":result"}, result_o, exp_res);
    check({name, ":busy_in_done"}, OPW'(busy_o), OPW'(0));
    check({name, ":unit_a"}, ua, a);
    check({name, ":unit_p"}, up, p);
    @(negedge clk);
    check({name, ":done_one_cycle"}, OPW'(done_o), OPW'(0));
    check({name, ":result_held"}, result_o, exp_res);
    check({name, ":n_loada"}, OPW'(n_la - b_la), OPW'(16));
    check({name, ":n_loadp"}, OPW'(n_lp - b_lp), OPW'(16));
    check({name, ":n_minv_en"}, OPW'(n_en - b_en), OPW'(1));
    check({name, ":n_outx1"}, OPW'(n_x1 - b_x1), OPW'((!bad && f == 2'b00) ? 16 : 0));
    check({name, ":n_outx2"}, OPW'(n_x2 - b_x2), OPW'((!bad && f == 2'b01) ? 16 : 0));
    check({name, ":n_outt"}, OPW'(n_t - b_t), OPW'((!bad && f == 2'b11) ? 16 : 0));
    check({name, ":strobe_rules"}, OPW'(n_viol - b_v), OPW'(0));
  endtask

  initial begin
    logic [OPW-1:0] a_seq, k, r;
    logic [1:0] flags [3];
    int waited;
    flags[0] = 2'b00; flags[1] = 2'b01; flags[2] = 2'b11;
    for (int i = 0; i < 16; i++) a_seq[i*16 +: 16] = 16'(i);
    k = 256'h1234_5678_90AB_CDEF_1234_5678_90AB_CDEF_1234_5678_90AB_CDEF_0FED_CBA9_8765_ABCD;

    #12;
    check("rst:busy", OPW'(busy_o), OPW'(0));
    check("rst:done", OPW'(done_o), OPW'(0));
    check("rst:err", OPW'(err_o), OPW'(0));
    check("rst:result", result_o, '0);
    check("rst:strobes", OPW'({u_if.loada, u_if.loadp, u_if.minv_en, u_if.outx1, u_if.outx2, u_if.outt}), OPW'(0));
    check("rst:datain", OPW'(u_if.datain), OPW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle:busy", OPW'(busy_o), OPW'(0));

    run_op("inv3mod7", 256'd3, 256'd7, 2'b00, 256'd5, 5, 1'b0, 1'b1, 1'b0);
    run_op("word_seq", a_seq, rand256(), 2'b00, rand256(), 3, 1'b0, 1'b0, 1'b0);
    run_op("regx2", rand256(), rand256(), 2'b01, k, 7, 1'b0, 1'b0, 1'b0);
    run_op("regt", rand256(), rand256(), 2'b11, k, 2, 1'b0, 1'b0, 1'b0);
    run_op("illegal", rand256(), rand256(), 2'b10, rand256(), 4, 1'b0, 1'b0, 1'b0);
    run_op("stale_rdy", rand256(), rand256(), 2'b01, rand256(), 1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      r = rand256();
      run_op("random", rand256(), rand256(), flags[$urandom_range(0, 2)], r,
             int'($urandom_range(1, 20)), 1'b0, 1'b0, 1'b0);
    end

    // Reset in the middle of LOAD_P word 7, then a fresh operation.
    u_flag = 2'b00; u_stale = 1'b0; u_mute = 1'b0; u_compute = 1'b0;
    @(negedge clk);
    start_i = 1'b1; a_i = rand256(); p_i = rand256();
    @(negedge clk);
    start_i = 1'b0;
    waited = 0;
    while (!(u_if.loadp && (n_lp % 16) == 7) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("midrst:reached_loadp_w7", OPW'(waited < 200), OPW'(1));
    rst_n = 1'b0;
    #1;
    check("midrst:busy", OPW'(busy_o), OPW'(0));
    check("midrst:result", result_o, '0);
    check("midrst:err_done", OPW'({err_o, done_o}), OPW'(0));
    check("midrst:strobes", OPW'({u_if.loada, u_if.loadp, u_if.minv_en, u_if.outx1, u_if.outx2, u_if.outt}), OPW'(0));
    check("midrst:datain", OPW'(u_if.datain), OPW'(0));
    n_lp = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("after_rst", rand256(), rand256(), 2'b11, rand256(), 6, 1'b0, 1'b0, 1'b0);

`ifdef MINV_TIMEOUT_EN
    run_op("timeout", rand256(), rand256(), 2'b00, rand256(), 1, 1'b0, 1'b0, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
